// File: rtl/transmitter_nb.sv
// Multi-frame asynchronous serial transmitter: sends a NUM_BYTES-frame message as back-to-back
// start/data/parity/stop frames, one bit per baud_rate edge.
module transmitter_nb #(
    parameter int unsigned NUM_BYTES = 3,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                                                     baud_rate,
    input  logic                                                     reset_n,
    input  logic                                                     start,
    input  logic [NUM_BYTES*DATA_BITS-1:0]                           data,
    output logic                                                     out,
    output logic                                                     data_transmitted,
    output logic                                                     busy,
    output logic [2:0]                                               state_out,
    output logic [((NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1)-1:0]     byte_index
);

    localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned MsgW = NUM_BYTES * DATA_BITS;

    if (NUM_BYTES < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("transmitter_nb: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                 state_q;
    logic [MsgW-1:0]        msg_q;
    logic [DATA_BITS-1:0]   frame_q;
    logic                   parity_q;
    logic [3:0]             bit_cnt_q;
    logic                   stop_cnt_q;

    assign state_out = state_q;

    always_ff @(posedge baud_rate or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            out              <= 1'b1;
            data_transmitted <= 1'b0;
            busy             <= 1'b0;
            byte_index       <= '0;
            msg_q            <= '0;
            frame_q          <= '0;
            parity_q         <= 1'b0;
            bit_cnt_q        <= '0;
            stop_cnt_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    out              <= 1'b1;
                    data_transmitted <= 1'b0;
                    if (start) begin
                        msg_q      <= data;
                        busy       <= 1'b1;
                        byte_index <= '0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    // Peel the next frame off the low end of the latched message.
                    out       <= 1'b0;
                    frame_q   <= msg_q[DATA_BITS-1:0];
                    parity_q  <= (^msg_q[DATA_BITS-1:0]) ^ (PARITY == 2);
                    msg_q     <= msg_q >> DATA_BITS;
                    bit_cnt_q <= 4'(DATA_BITS - 1);
                    state_q   <= StData;
                end
                StData: begin
                    if (MSB_FIRST != 0) begin
                        out     <= frame_q[DATA_BITS-1];
                        frame_q <= frame_q << 1;
                    end else begin
                        out     <= frame_q[0];
                        frame_q <= frame_q >> 1;
                    end
                    if (bit_cnt_q == 4'd0) begin
                        state_q <= (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                    end
                end
                StParity: begin
                    out     <= parity_q;
                    state_q <= StStop;
                end
                StStop: begin
                    out <= 1'b1;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        stop_cnt_q <= 1'b0;
                        if (byte_index == IdxW'(NUM_BYTES - 1)) begin
                            data_transmitted <= 1'b1;
                            busy             <= 1'b0;
                            byte_index       <= '0;
                            state_q          <= StIdle;
                        end else begin
                            byte_index <= byte_index + IdxW'(1);
                            state_q    <= StStart;
                        end
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    out              <= 1'b1;
                    data_transmitted <= 1'b0;
                    busy             <= 1'b0;
                    byte_index       <= '0;
                    state_q          <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter_nb.sv
// Bench for transmitter_nb: three parameter sets driven with random starts/data, each checked
// every edge against a frame-position model, plus literal waveform pins.
module tb_transmitter_nb;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] data_v [3];
    logic [2:0]  out_v, done_v, busy_v;
    logic [2:0][2:0] st_v;

    int n_cmp = 0;
    int n_bad = 0;

    logic h_out  [3][41];
    logic h_done [3][41];
    logic h_busy [3][41];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar G = 0; G < 3; G++) begin : g_inst
        localparam int NB  = (G == 0) ? 3 : (G == 1) ? 2 : 1;
        localparam int DB  = (G == 0) ? 8 : (G == 1) ? 7 : 5;
        localparam int PAR = (G == 0) ? 0 : (G == 1) ? 1 : 2;
        localparam int SB  = (G == 1) ? 2 : 1;
        localparam int MSB = (G == 1) ? 1 : 0;
        localparam int F   = 2 + DB + ((PAR != 0) ? 1 : 0) + SB - 1;
        localparam int W   = NB * DB;
        localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

        logic           out, done, busy;
        logic [2:0]     st;
        logic [BIW-1:0] bi;

        transmitter_nb #(
            .NUM_BYTES (NB),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB),
            .MSB_FIRST (MSB)
        ) u_dut (
            .baud_rate        (clk),
            .reset_n          (rst_n),
            .start            (start),
            .data             (data_v[G][W-1:0]),
            .out              (out),
            .data_transmitted (done),
            .busy             (busy),
            .state_out        (st),
            .byte_index       (bi)
        );

        assign out_v[G]  = out;
        assign done_v[G] = done;
        assign busy_v[G] = busy;
        assign st_v[G]   = st;

        // Model: outputs are a pure function of edges elapsed since the accept edge.
        initial begin : model
            bit          act;
            int          e, k, p, np, idx, x_bi;
            logic [23:0] msg;
            logic [8:0]  fr;
            logic        x_out, x_busy, x_done;
            logic [2:0]  x_st;
            act = 0;
            e   = 0;
            msg = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    act = 0;
                end else if (!act) begin
                    if (start) begin
                        act = 1;
                        e   = 0;
                        msg = data_v[G] & 24'((64'd1 << W) - 1);
                    end
                end else begin
                    e++;
                end
                if (!act) begin
                    x_out = 1; x_busy = 0; x_done = 0; x_st = 0; x_bi = 0;
                end else if (e == 0) begin
                    x_out = 1; x_busy = 1; x_done = 0; x_st = 1; x_bi = 0;
                end else begin
                    k  = (e - 1) / F;
                    p  = (e - 1) % F;
                    fr = 9'((msg >> (k * DB)) & 24'((1 << DB) - 1));
                    if (p == 0) x_out = 0;
                    else if (p <= DB) begin
                        idx   = (MSB != 0) ? DB - p : p - 1;
                        x_out = fr[idx];
                    end else if (PAR != 0 && p == DB + 1) x_out = (^fr) ^ (PAR == 2);
                    else x_out = 1;
                    x_done = (e == NB * F);
                    x_busy = !x_done;
                    np     = e % F;
                    if (x_done) x_st = 0;
                    else if (np == 0) x_st = 1;
                    else if (np <= DB) x_st = 2;
                    else if (PAR != 0 && np == DB + 1) x_st = 3;
                    else x_st = 4;
                    x_bi = x_done ? 0 : e / F;
                    if (x_done) act = 0;
                end
                check($sformatf("i%0d_out e%0d", G, e), 32'(out), 32'(x_out));
                check($sformatf("i%0d_busy e%0d", G, e), 32'(busy), 32'(x_busy));
                check($sformatf("i%0d_done e%0d", G, e), 32'(done), 32'(x_done));
                check($sformatf("i%0d_state e%0d", G, e), 32'(st), 32'(x_st));
                check($sformatf("i%0d_byte_index e%0d", G, e), 32'(bi), 32'(x_bi));
            end
        end
    end

    initial begin : stim
        logic [7:0] v;
        int         ndone;
        data_v[0] = '0;
        data_v[1] = '0;
        data_v[2] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed message, data scrambled right after the accept edge.
        data_v[0] = 24'hA53C0F;
        data_v[1] = 24'h000013;
        data_v[2] = 24'h000013;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 3; g++) data_v[g] = 24'($urandom);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                h_out[g][i]  = out_v[g];
                h_done[g][i] = done_v[g];
                h_busy[g][i] = busy_v[g];
            end
        end
        check("lit0_start_bit", 32'(h_out[0][1]), 32'd0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) v[i] = h_out[0][2 + 10 * f + i];
            check($sformatf("lit0_frame%0d_data", f), 32'(v), (f == 0) ? 32'h0F :
                  (f == 1) ? 32'h3C : 32'hA5);
        end
        check("lit0_stop_bit", 32'(h_out[0][10]), 32'd1);
        ndone = 0;
        for (int i = 1; i <= 40; i++) ndone += int'(h_done[0][i]);
        check("lit0_done_count", 32'(ndone), 32'd1);
        check("lit0_done_edge30", 32'(h_done[0][30]), 32'd1);
        check("lit0_busy_edge29", 32'(h_busy[0][29]), 32'd1);
        check("lit0_busy_edge30", 32'(h_busy[0][30]), 32'd0);
        v = '0;
        for (int i = 2; i <= 8; i++) v = {v[6:0], h_out[1][i]};
        check("lit1_msb_first_data", 32'(v), 32'h13);
        check("lit1_even_parity", 32'(h_out[1][9]), 32'd1);
        check("lit1_two_stops", 32'({h_out[1][10], h_out[1][11], h_out[1][12]}), 32'b110);
        check("lit1_done_edge21", 32'(h_done[1][21]), 32'd0);
        check("lit1_done_edge22", 32'(h_done[1][22]), 32'd1);
        v = '0;
        for (int i = 0; i < 5; i++) v[i] = h_out[2][2 + i];
        check("lit2_lsb_first_data", 32'(v), 32'h13);
        check("lit2_odd_parity", 32'(h_out[2][7]), 32'd0);
        check("lit2_done_edge8", 32'(h_done[2][8]), 32'd1);

        // Random starts and data.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            for (int g = 0; g < 3; g++) data_v[g] = 24'($urandom);
        end

        // start held high: back-to-back messages.
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            start = 1'b1;
            for (int g = 0; g < 3; g++) data_v[g] = 24'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-message.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst%0d_out", g), 32'(out_v[g]), 32'd1);
            check($sformatf("rst%0d_state", g), 32'(st_v[g]), 32'd0);
            check($sformatf("rst%0d_busy", g), 32'(busy_v[g]), 32'd0);
            check($sformatf("rst%0d_done", g), 32'(done_v[g]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        for (int g = 0; g < 3; g++) data_v[g] = 24'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            for (int g = 0; g < 3; g++) data_v[g] = 24'($urandom);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
